// File: rtl/seq_matmul_param_pkg.sv
// Shared types and helpers for the sequential parametrised matrix multiplier.
package seq_matmul_param_pkg;

  typedef enum logic [1:0] {IDLE, MAC, EMIT, DONE} state_e;

  // Index width never collapses to zero so M/K/N = 1 still gets a 1-bit port.
  function automatic int idx_w(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/seq_matmul_param_if.sv
// Operand fetch, result handshake and status bundle of seq_matmul_param.
interface seq_matmul_param_if
  import seq_matmul_param_pkg::*;
#(
  parameter int M      = 4,
  parameter int K      = 4,
  parameter int N      = 4,
  parameter int DATA_W = 32
);
  localparam int MW = idx_w(M);
  localparam int KW = idx_w(K);
  localparam int NW = idx_w(N);

  logic                     start;
  logic                     acc_mode;
  logic signed [DATA_W-1:0] a_in;
  logic signed [DATA_W-1:0] b_in;
  logic signed [DATA_W-1:0] current_element;
  logic                     z_ack;
  logic [MW-1:0]            a_i;
  logic [KW-1:0]            a_k;
  logic [KW-1:0]            b_k;
  logic [NW-1:0]            b_j;
  logic signed [DATA_W-1:0] z_out;
  logic [MW-1:0]            z_i;
  logic [NW-1:0]            z_j;
  logic                     z_stb;
  logic                     busy;
  logic                     done;
  logic                     overflow;

  modport slave (
    input  start, acc_mode, a_in, b_in, current_element, z_ack,
    output a_i, a_k, b_k, b_j, z_out, z_i, z_j, z_stb, busy, done, overflow
  );

  modport master (
    output start, acc_mode, a_in, b_in, current_element, z_ack,
    input  a_i, a_k, b_k, b_j, z_out, z_i, z_j, z_stb, busy, done, overflow
  );
endinterface

// File: rtl/seq_matmul_param_mac_unit.sv
// Signed MAC with clearable accumulator, optional C addend, and the
// saturate/truncate plus range-check applied to the finished dot product.
module matmul_mac_unit #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 2*DATA_W + 3,
  parameter int SAT    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     add_c,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] c,
  output logic signed [DATA_W-1:0] z,
  output logic                     ovf
);
  localparam logic signed [ACC_W-1:0] MAXV =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_q, acc_d, c_ext, sum;

  always_comb begin
    prod  = a * b;
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  end

  always_comb begin
    c_ext = '0;
    if (add_c) c_ext = {{(ACC_W-DATA_W){c[DATA_W-1]}}, c};
    sum = acc_q + c_ext;
    ovf = (sum > MAXV) || (sum < MINV);
    z   = sum[DATA_W-1:0];
    // Overflow is reported either way; only the emitted value depends on SAT.
    if (SAT != 0 && ovf)
      z = sum[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc_q <= '0;
    else      acc_q <= acc_d;
  end
endmodule

// File: rtl/seq_matmul_param.sv
// Z = [C +] A(MxK)*B(KxN), one MAC per cycle, each element emitted on a
// strobe/ack handshake; operands read through combinational index ports.
module seq_matmul_param
  import seq_matmul_param_pkg::*;
#(
  parameter int M      = 4,
  parameter int K      = 4,
  parameter int N      = 4,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 2*DATA_W + $clog2(K) + 1,
  parameter int SAT    = 1
) (
  input logic          clk,
  input logic          rst,
  seq_matmul_param_if.slave bus
);
  localparam int MW = idx_w(M);
  localparam int KW = idx_w(K);
  localparam int NW = idx_w(N);
  localparam logic [MW-1:0] M_LAST = MW'(M-1);
  localparam logic [KW-1:0] K_LAST = KW'(K-1);
  localparam logic [NW-1:0] N_LAST = NW'(N-1);

  state_e             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [MW-1:0]      zi_q, zi_d;
  logic [NW-1:0]      zj_q, zj_d;
  logic [DATA_W-1:0]  zout_q, zout_d;
  logic               stb_q, stb_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic               accm_q, accm_d;
  logic               mac_clr, mac_en, mac_ovf;
  logic signed [DATA_W-1:0] mac_z;

  matmul_mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SAT(SAT)) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr   (mac_clr),
    .en    (mac_en),
    .add_c (accm_q),
    .a     (bus.a_in),
    .b     (bus.b_in),
    .c     (bus.current_element),
    .z     (mac_z),
    .ovf   (mac_ovf)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    zi_d    = zi_q;
    zj_d    = zj_q;
    zout_d  = zout_q;
    stb_d   = stb_q;
    ovf_d   = ovf_q;
    accm_d  = accm_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = MAC;
        accm_d  = bus.acc_mode;
        k_d     = '0;
        zi_d    = '0;
        zj_d    = '0;
        ovf_d   = 1'b0;
        mac_clr = 1'b1;
      end
      MAC: begin
        mac_en = 1'b1;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = EMIT;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      EMIT: begin
        // First EMIT cycle captures the result; later cycles wait for the ack.
        if (!stb_q) begin
          zout_d = mac_z;
          ovf_d  = ovf_q | mac_ovf;
          stb_d  = 1'b1;
        end else if (bus.z_ack) begin
          stb_d = 1'b0;
          if (zi_q == M_LAST && zj_q == N_LAST) begin
            state_d = DONE;
          end else begin
            state_d = MAC;
            mac_clr = 1'b1;
            k_d     = '0;
            if (zj_q == N_LAST) begin
              zj_d = '0;
              zi_d = zi_q + MW'(1);
            end else begin
              zj_d = zj_q + NW'(1);
            end
          end
        end
      end
      DONE: if (!bus.start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == MAC) || (state_d == EMIT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      zi_q    <= '0;
      zj_q    <= '0;
      zout_q  <= '0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      accm_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      zi_q    <= zi_d;
      zj_q    <= zj_d;
      zout_q  <= zout_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      accm_q  <= accm_d;
    end
  end

  assign bus.a_i      = zi_q;
  assign bus.a_k      = k_q;
  assign bus.b_k      = k_q;
  assign bus.b_j      = zj_q;
  assign bus.z_i      = zi_q;
  assign bus.z_j      = zj_q;
  assign bus.z_out    = zout_q;
  assign bus.z_stb    = stb_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_seq_matmul_param.sv
// Directed bench: 2x3*3x2 matrix runs on a 32-bit instance, plus 8-bit
// 1x2*2x1 instances (saturating and truncating) driven from a vector table.
module tb_seq_matmul_param;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  seq_matmul_param_if #(.M(2), .K(3), .N(2), .DATA_W(32)) i0 ();
  seq_matmul_param_if #(.M(1), .K(2), .N(1), .DATA_W(8))  i1 ();
  seq_matmul_param_if #(.M(1), .K(2), .N(1), .DATA_W(8))  i2 ();

  seq_matmul_param #(.M(2), .K(3), .N(2), .DATA_W(32), .SAT(1)) u0 (.clk(clk), .rst(rst), .bus(i0));
  seq_matmul_param #(.M(1), .K(2), .N(1), .DATA_W(8),  .SAT(1)) u1 (.clk(clk), .rst(rst), .bus(i1));
  seq_matmul_param #(.M(1), .K(2), .N(1), .DATA_W(8),  .SAT(0)) u2 (.clk(clk), .rst(rst), .bus(i2));

  int A0 [2][3];
  int B0 [3][2];
  int cval;
  logic signed [7:0] A1 [2];
  logic signed [7:0] B1 [2];
  int EXP [4];

  assign i0.a_in            = A0[i0.a_i][i0.a_k];
  assign i0.b_in            = B0[i0.b_k][i0.b_j];
  assign i0.current_element = cval;
  assign i1.a_in            = A1[i1.a_k];
  assign i1.b_in            = B1[i1.b_k];
  assign i1.current_element = '0;
  assign i2.a_in            = A1[i2.a_k];
  assign i2.b_in            = B1[i2.b_k];
  assign i2.current_element = '0;

  typedef struct {
    logic signed [7:0] a0, a1, b0, b1;
    logic signed [7:0] esat, etr;
    bit                eovf;
  } vec_t;
  vec_t vt [7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic wait_stb(output int n);
    n = 0;
    while (!i0.z_stb && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic ack0();
    i0.z_ack = 1'b1;
    tick();
    i0.z_ack = 1'b0;
  endtask

  // Leaves start high on exit so the caller can check the DONE hold.
  task automatic run_full(input bit acc, input bit slow);
    int n;
    i0.acc_mode = acc;
    i0.start    = 1'b1;
    tick();
    i0.acc_mode = 1'b0;
    for (int e = 0; e < 4; e++) begin
      if (slow && e == 2) begin
        i0.z_ack = 1'b1;
        tick();
        i0.z_ack = 1'b0;
        chk("stray_zi", i0.z_i, 1);
        chk("stray_zj", i0.z_j, 0);
        chk("stray_stb", i0.z_stb, 0);
      end
      wait_stb(n);
      chk("stb_seen", i0.z_stb, 1);
      if (!(slow && e == 2)) chk("elem_latency", n, 4);
      chk("z_i", i0.z_i, e / 2);
      chk("z_j", i0.z_j, e % 2);
      chk("z_out", i0.z_out, EXP[e] + (acc ? 100 : 0));
      if (slow && e == 1) begin
        repeat (5) begin
          tick();
          chk("hold_stb", i0.z_stb, 1);
          chk("hold_zout", i0.z_out, 64);
          chk("hold_zj", i0.z_j, 1);
        end
      end
      ack0();
      chk("stb_fall", i0.z_stb, 0);
      if (slow && e == 1) begin
        chk("adv_zi", i0.z_i, 1);
        chk("adv_zj", i0.z_j, 0);
      end
    end
    chk("done", i0.done, 1);
    chk("busy_done", i0.busy, 0);
    chk("ovf", i0.overflow, 0);
  endtask

  task automatic run_small(input vec_t v);
    int n;
    A1[0] = v.a0; A1[1] = v.a1;
    B1[0] = v.b0; B1[1] = v.b1;
    i1.start = 1'b1;
    i2.start = 1'b1;
    tick();
    n = 0;
    while (!i1.z_stb && n < 50) begin
      tick();
      n++;
    end
    chk("s_latency", n, 3);
    chk("s_zsat", i1.z_out, v.esat);
    chk("s_ztrunc", i2.z_out, v.etr);
    chk("s_ovf_sat", i1.overflow, v.eovf);
    chk("s_ovf_trunc", i2.overflow, v.eovf);
    i1.z_ack = 1'b1;
    i2.z_ack = 1'b1;
    tick();
    i1.z_ack = 1'b0;
    i2.z_ack = 1'b0;
    chk("s_done", i1.done & i2.done, 1);
    i1.start = 1'b0;
    i2.start = 1'b0;
    tick();
  endtask

  initial begin
    A0 = '{'{1, 2, 3}, '{4, 5, 6}};
    B0 = '{'{7, 8}, '{9, 10}, '{11, 12}};
    EXP = '{58, 64, 139, 154};
    cval = 0;
    A1 = '{8'sd0, 8'sd0};
    B1 = '{8'sd0, 8'sd0};
    vt[0] = '{100, 100, 2, 2, 127, -112, 1};
    vt[1] = '{-100, -100, 2, 2, -128, 112, 1};
    vt[2] = '{3, -4, 5, 6, -9, -9, 0};
    vt[3] = '{127, 1, 1, 0, 127, 127, 0};
    vt[4] = '{-128, 0, 1, 5, -128, -128, 0};
    vt[5] = '{64, 64, 1, 1, 127, -128, 1};
    vt[6] = '{-128, -128, -128, -128, 127, 0, 1};
    {i0.start, i0.acc_mode, i0.z_ack} = '0;
    {i1.start, i1.acc_mode, i1.z_ack} = '0;
    {i2.start, i2.acc_mode, i2.z_ack} = '0;
    rst = 1'b0;
    repeat (2) tick();
    chk("rst_zout", i0.z_out, 0);
    chk("rst_stb", i0.z_stb, 0);
    chk("rst_busy", i0.busy, 0);
    chk("rst_done", i0.done, 0);
    chk("rst_ovf", i0.overflow, 0);
    chk("rst_idx", {i0.z_i, i0.z_j, i0.a_k}, 0);
    rst = 1'b1;
    tick();

    // Plain product, then start held high across DONE.
    run_full(1'b0, 1'b0);
    repeat (3) tick();
    chk("hold_done", i0.done, 1);
    chk("hold_busy", i0.busy, 0);
    chk("hold_nostb", i0.z_stb, 0);
    i0.start = 1'b0;
    tick();
    chk("idle_done", i0.done, 0);
    chk("idle_busy", i0.busy, 0);

    cval = 100;
    run_full(1'b1, 1'b0);
    i0.start = 1'b0;
    tick();
    cval = 0;

    run_full(1'b0, 1'b1);
    i0.start = 1'b0;
    tick();

    // Abort during the third element's MAC phase.
    begin
      int n;
      i0.start = 1'b1;
      tick();
      for (int e = 0; e < 2; e++) begin
        wait_stb(n);
        chk("pre_rst_zout", i0.z_out, EXP[e]);
        ack0();
      end
      tick();
      chk("pre_rst_busy", i0.busy, 1);
      rst = 1'b0;
      #1;
      chk("arst_zout", i0.z_out, 0);
      chk("arst_busy", i0.busy, 0);
      chk("arst_idx", {i0.z_i, i0.z_j, i0.a_k}, 0);
      i0.start = 1'b0;
      repeat (3) tick();
      chk("arst_stb", i0.z_stb, 0);
      chk("arst_done", i0.done, 0);
      rst = 1'b1;
      tick();
    end
    run_full(1'b0, 1'b0);
    i0.start = 1'b0;
    tick();

    for (int v = 0; v < 7; v++) run_small(vt[v]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
